output_argmax_tracker: RTL and testbench
========================================

OUTPUT_ARGMAX_TRACKER -- requirements
Module: output_argmax_tracker

Interface
REQ-001 SHALL have parameter width, default 10: activation bit width, signed two's complement.
REQ-002 SHALL have parameter N, default 16: output neurons per sample; power of 2, N >= 2.
REQ-003 SHALL have parameter Z, default 1: activations per beat; power of 2, Z divides N.
REQ-004 SHALL have parameter TIE_MODE, default 0: 0 = lowest index wins ties, 1 = highest index wins ties.
REQ-005 SHALL have parameter WIN, default 100: samples per accuracy window, WIN >= 1.
REQ-006 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port act_valid  input  1  current beat of act_in/y_in is valid.
REQ-009 SHALL have port act_in  input  width*Z  Z activations; lane k in bits [width*k +: width] is neuron beat*Z+k.
REQ-010 SHALL have port y_in  input  Z  ideal-output slice; bit k belongs to neuron beat*Z+k.
REQ-011 SHALL have port abort  input  1  synchronous discard of the partial sample.
REQ-012 SHALL have port a_out_alln  output  N  one-hot predicted class; held until the next result.
REQ-013 SHALL have port max_pos  output  clog2(N)  index of the predicted class.
REQ-014 SHALL have port result_valid  output  1  one-cycle pulse when a new result is presented.
REQ-015 SHALL have port correct  output  1  prediction equals the ideal label; qualified by result_valid.
REQ-016 SHALL have port y_err  output  1  the sample's y was not one-hot; qualified by result_valid.
REQ-017 SHALL have port acc_count  output  clog2(WIN+1)  correct predictions in the last completed window.
REQ-018 SHALL have port acc_valid  output  1  one-cycle pulse when acc_count updates.

Function
REQ-019 SHALL keep a beat counter 0..N/Z-1, advanced only on act_valid=1 and wrapping to 0 after beat N/Z-1.
REQ-020 SHALL hold every piece of internal state unchanged while act_valid=0 (stall); stalls may occur mid-sample.
REQ-021 SHALL, on each valid beat, find the combinational max over the Z lanes, applying the TIE_MODE tie rule within the beat.
REQ-022 SHALL compare the beat max against the running max: update when strictly greater (TIE_MODE 0) or greater-or-equal (TIE_MODE 1).
REQ-023 SHALL build the running max position as {beat counter, lane index}.
REQ-024 SHALL use most-negative ({1,0...0}) as the running max at the start of every sample, so an all-negative sample still yields a valid index.
REQ-025 SHALL record the ideal label position from the y_in bits and count the set bits, saturating at 2.
REQ-026 SHALL fold the final beat (beat N/Z-1) into the result before it is registered.
REQ-027 SHALL, on the clock edge that accepts the final beat, register the result and pulse result_valid for the following cycle.
REQ-028 SHALL produce a result with a latency of exactly 1 clk from final-beat acceptance.
REQ-029 SHALL, with the result, set a_out_alln to one-hot at max_pos and set correct and y_err.
REQ-030 SHALL set y_err=1 when the y_in bit count over the sample is not exactly 1, and then force correct=0.
REQ-031 SHALL re-initialise the running state on that same edge, so a back-to-back sample may start the next cycle with no bubble.
REQ-032 SHALL, on abort=1, clear the beat counter and running state on that edge without producing a result.
REQ-033 SHALL give abort priority over a simultaneous act_valid=1; that beat is discarded.
REQ-034 SHALL keep a window sample counter and a correct counter, advanced with each result.
REQ-035 SHALL, on the WIN-th result, load acc_count with the window total (including that result), pulse acc_valid in the same cycle as result_valid, and clear both counters.
REQ-036 SHALL ensure the correct counter never exceeds WIN and does not wrap.
REQ-037 SHALL not let abort affect the window counters.
REQ-038 SHALL use signed comparisons throughout.

Reset
REQ-039 SHALL, while reset=1 (independent of clk), drive a_out_alln=0, max_pos=0, result_valid=0, correct=0, y_err=0, acc_count=0, acc_valid=0.
REQ-040 SHALL, while reset=1, clear the beat counter and window counters and set the running max to most-negative.
REQ-041 SHALL, on reset asserted mid-sample, discard the partial sample; the first valid beat after release is beat 0.

Verification
REQ-042 SHALL cover: N=16, Z=4, TIE_MODE=0; 4 contiguous beats, neuron 9 = 0x0F0, others 0x010, y one-hot at 9 -> result_valid 1 clk after beat 3, max_pos=9, a_out_alln=0x0200, correct=1, y_err=0.
REQ-043 SHALL cover: neurons 2 and 13 both 0x100, rest 0 -> TIE_MODE 0 gives max_pos=2; TIE_MODE 1 gives max_pos=13.
REQ-044 SHALL cover: all activations 0x3FF (-1) except neuron 5 = 0x3FE -> max_pos=0 (TIE_MODE 0); y with two bits set -> y_err=1, correct=0.
REQ-045 SHALL cover: act_valid low 3 cycles between beats 1 and 2 -> result identical to the unstalled run, result arriving 3 cycles later.
REQ-046 SHALL cover: abort during beat 2, then a full sample -> exactly one result_valid pulse, for the second sample; async reset mid-sample -> all outputs 0 immediately.
REQ-047 SHALL cover: WIN=4; results correct 1,0,1,1 -> acc_valid coincident with the 4th result_valid, acc_count=3, and the next window starts from 0.

Source files
------------

// File: rtl/output_argmax_tracker.sv
// Streaming argmax over N signed activations delivered Z per beat, with an
// ideal-label check against a one-hot y vector and a windowed accuracy count.
module output_argmax_tracker #(
  parameter int width    = 10,
  parameter int N        = 16,
  parameter int Z        = 1,
  parameter int TIE_MODE = 0,
  parameter int WIN      = 100
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       act_valid,
  input  logic [width*Z-1:0]         act_in,
  input  logic [Z-1:0]               y_in,
  input  logic                       abort,
  output logic [N-1:0]               a_out_alln,
  output logic [$clog2(N)-1:0]       max_pos,
  output logic                       result_valid,
  output logic                       correct,
  output logic                       y_err,
  output logic [$clog2(WIN+1)-1:0]   acc_count,
  output logic                       acc_valid
);

  localparam int BEATS = N / Z;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(N);
  localparam int AW    = $clog2(WIN + 1);
  localparam logic signed [width-1:0] MOST_NEG = {1'b1, {(width-1){1'b0}}};

  logic [CW-1:0]             beat_reg;
  logic signed [width-1:0]   run_max_reg;
  logic [PW-1:0]             run_pos_reg;
  logic [PW-1:0]             y_pos_reg;
  logic [1:0]                y_cnt_reg;
  logic [AW-1:0]             win_cnt_reg;
  logic [AW-1:0]             corr_cnt_reg;

  logic signed [width-1:0]   lane_val [Z];

  genvar gi;
  generate
    for (gi = 0; gi < Z; gi++) begin : g_lane
      assign lane_val[gi] = act_in[width*gi +: width];
    end
  endgenerate

  logic signed [width-1:0]   beat_max;
  logic [PW-1:0]             beat_lane;
  logic [PW-1:0]             beat_base;
  logic [1:0]                y_beat_cnt;
  logic [PW-1:0]             y_beat_lane;
  logic                      take;
  logic signed [width-1:0]   fold_max;
  logic [PW-1:0]             fold_pos;
  logic [2:0]                y_sum;
  logic [1:0]                fold_y_cnt;
  logic [PW-1:0]             fold_y_pos;
  logic                      last_beat;
  logic                      finish;
  logic                      fold_correct;

  always_comb begin
    beat_max    = lane_val[0];
    beat_lane   = '0;
    y_beat_cnt  = 2'd0;
    y_beat_lane = '0;
    // Lane 0 seeds the beat max; later lanes win on > or >= by tie rule.
    for (int k = 1; k < Z; k++) begin
      if ((TIE_MODE != 0) ? (lane_val[k] >= beat_max) : (lane_val[k] > beat_max)) begin
        beat_max  = lane_val[k];
        beat_lane = PW'(k);
      end
    end
    for (int k = 0; k < Z; k++) begin
      if (y_in[k]) begin
        if (y_beat_cnt != 2'd2) y_beat_cnt = y_beat_cnt + 2'd1;
        y_beat_lane = PW'(k);
      end
    end
  end

  assign beat_base    = PW'(int'(beat_reg) * Z);
  assign take         = (TIE_MODE != 0) ? (beat_max >= run_max_reg) : (beat_max > run_max_reg);
  assign fold_max     = take ? beat_max : run_max_reg;
  assign fold_pos     = take ? (beat_base + beat_lane) : run_pos_reg;
  assign y_sum        = {1'b0, y_cnt_reg} + {1'b0, y_beat_cnt};
  assign fold_y_cnt   = (y_sum >= 3'd2) ? 2'd2 : y_sum[1:0];
  assign fold_y_pos   = (y_beat_cnt != 2'd0) ? (beat_base + y_beat_lane) : y_pos_reg;
  assign last_beat    = (beat_reg == CW'(BEATS - 1));
  assign finish       = act_valid && !abort && last_beat;
  assign fold_correct = (fold_y_cnt == 2'd1) && (fold_y_pos == fold_pos);

  // Running state: re-seeded on abort and on the final beat so samples can abut.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_reg    <= '0;
      run_max_reg <= MOST_NEG;
      run_pos_reg <= '0;
      y_pos_reg   <= '0;
      y_cnt_reg   <= 2'd0;
    end else if (abort || finish) begin
      beat_reg    <= '0;
      run_max_reg <= MOST_NEG;
      run_pos_reg <= '0;
      y_pos_reg   <= '0;
      y_cnt_reg   <= 2'd0;
    end else if (act_valid) begin
      beat_reg    <= beat_reg + CW'(1);
      run_max_reg <= fold_max;
      run_pos_reg <= fold_pos;
      y_pos_reg   <= fold_y_pos;
      y_cnt_reg   <= fold_y_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out_alln   <= '0;
      max_pos      <= '0;
      result_valid <= 1'b0;
      correct      <= 1'b0;
      y_err        <= 1'b0;
      acc_count    <= '0;
      acc_valid    <= 1'b0;
      win_cnt_reg  <= '0;
      corr_cnt_reg <= '0;
    end else begin
      result_valid <= finish;
      acc_valid    <= 1'b0;
      if (finish) begin
        a_out_alln <= {{(N-1){1'b0}}, 1'b1} << fold_pos;
        max_pos    <= fold_pos;
        correct    <= fold_correct;
        y_err      <= (fold_y_cnt != 2'd1);
        if (win_cnt_reg == AW'(WIN - 1)) begin
          acc_count    <= corr_cnt_reg + AW'(fold_correct);
          acc_valid    <= 1'b1;
          win_cnt_reg  <= '0;
          corr_cnt_reg <= '0;
        end else begin
          win_cnt_reg  <= win_cnt_reg + AW'(1);
          corr_cnt_reg <= corr_cnt_reg + AW'(fold_correct);
        end
      end
    end
  end

endmodule

// File: tb/tb_output_argmax_tracker.sv
// Drives two trackers (lowest-index and highest-index tie rules) with the same
// beats and compares every result against a whole-sample argmax model.
module tb_output_argmax_tracker;

  localparam int W  = 10;
  localparam int NN = 16;
  localparam int ZZ = 4;
  localparam int WN = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              act_valid;
  logic              abort;
  logic [W*ZZ-1:0]   act_in;
  logic [ZZ-1:0]     y_in;

  logic [NN-1:0]     a_out [2];
  logic [3:0]        mp    [2];
  logic              rv    [2];
  logic              cor   [2];
  logic              ye    [2];
  logic [2:0]        ac    [2];
  logic              av    [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      output_argmax_tracker #(
        .width(W), .N(NN), .Z(ZZ), .TIE_MODE(gi), .WIN(WN)
      ) dut (
        .clk(clk), .reset(reset), .act_valid(act_valid), .act_in(act_in),
        .y_in(y_in), .abort(abort), .a_out_alln(a_out[gi]), .max_pos(mp[gi]),
        .result_valid(rv[gi]), .correct(cor[gi]), .y_err(ye[gi]),
        .acc_count(ac[gi]), .acc_valid(av[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  logic signed [W-1:0] sv [NN];
  logic [NN-1:0]       sy;
  int errors = 0;
  int checks = 0;
  int wc [2];
  int cc [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.a_out%0d", tag, d), 32'(a_out[d]), 32'd0);
      chk($sformatf("%s.max_pos%0d", tag, d), 32'(mp[d]), 32'd0);
      chk($sformatf("%s.rv%0d", tag, d), 32'(rv[d]), 32'd0);
      chk($sformatf("%s.correct%0d", tag, d), 32'(cor[d]), 32'd0);
      chk($sformatf("%s.y_err%0d", tag, d), 32'(ye[d]), 32'd0);
      chk($sformatf("%s.acc_count%0d", tag, d), 32'(ac[d]), 32'd0);
      chk($sformatf("%s.acc_valid%0d", tag, d), 32'(av[d]), 32'd0);
    end
  endtask

  task automatic drive_beat(input int b);
    act_valid = 1'b1;
    for (int k = 0; k < ZZ; k++) act_in[W*k +: W] = sv[b*ZZ + k];
    y_in = sy[b*ZZ +: ZZ];
  endtask

  // Whole-sample reference: global max, then first/last index holding it.
  task automatic check_result(input string tag);
    int mx, ycnt, ypos, pred, corr;
    mx = -(1 << (W-1));
    ycnt = 0; ypos = 0;
    for (int i = 0; i < NN; i++) begin
      if (int'(sv[i]) > mx) mx = int'(sv[i]);
      if (sy[i]) begin ycnt++; ypos = i; end
    end
    for (int d = 0; d < 2; d++) begin
      pred = -1;
      for (int i = 0; i < NN; i++)
        if (int'(sv[i]) == mx && (d == 1 || pred < 0)) pred = i;
      corr = (ycnt == 1 && ypos == pred) ? 1 : 0;
      chk($sformatf("%s.rv%0d", tag, d), 32'(rv[d]), 32'd1);
      chk($sformatf("%s.max_pos%0d", tag, d), 32'(mp[d]), 32'(pred));
      chk($sformatf("%s.a_out%0d", tag, d), 32'(a_out[d]), 32'd1 << pred);
      chk($sformatf("%s.correct%0d", tag, d), 32'(cor[d]), 32'(corr));
      chk($sformatf("%s.y_err%0d", tag, d), 32'(ye[d]), (ycnt != 1) ? 32'd1 : 32'd0);
      wc[d]++;
      cc[d] += corr;
      if (wc[d] == WN) begin
        chk($sformatf("%s.acc_valid%0d", tag, d), 32'(av[d]), 32'd1);
        chk($sformatf("%s.acc_count%0d", tag, d), 32'(ac[d]), 32'(cc[d]));
        wc[d] = 0;
        cc[d] = 0;
      end else begin
        chk($sformatf("%s.acc_valid%0d", tag, d), 32'(av[d]), 32'd0);
      end
    end
    $display("sample %s: argmax_val=%0d ycnt=%0d max_pos=%0d/%0d correct=%0d/%0d",
             tag, mx, ycnt, mp[0], mp[1], cor[0], cor[1]);
  endtask

  task automatic run_sample(input string tag, input int stall_after, input int stall_len);
    for (int b = 0; b < NN/ZZ; b++) begin
      drive_beat(b);
      @(posedge clk); #1;
      if (b < NN/ZZ - 1) begin
        chk($sformatf("%s.early_rv_b%0d", tag, b), {30'd0, rv[1], rv[0]}, 32'd0);
        if (b == stall_after) begin
          act_valid = 1'b0;
          for (int s = 0; s < stall_len; s++) begin
            @(posedge clk); #1;
            chk($sformatf("%s.stall_rv_%0d", tag, s), {30'd0, rv[1], rv[0]}, 32'd0);
          end
        end
      end
    end
    act_valid = 1'b0;
    check_result(tag);
  endtask

  task automatic fill(input logic signed [W-1:0] v);
    for (int i = 0; i < NN; i++) sv[i] = v;
    sy = '0;
  endtask

  task automatic win_sample(input int p, input bit good);
    fill(10'sd5);
    sv[p] = 10'sd200;
    sy = '0;
    sy[good ? p : (p + 1) % NN] = 1'b1;
  endtask

  initial begin
    int mx, first;
    reset = 1'b1; act_valid = 1'b0; abort = 1'b0; act_in = '0; y_in = '0;
    wc[0] = 0; wc[1] = 0; cc[0] = 0; cc[1] = 0;
    #12;
    chk_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Neuron 9 stands out, label at 9.
    fill(10'sh010); sv[9] = 10'sh0F0; sy[9] = 1'b1;
    run_sample("basic", -1, 0);

    // Same sample with a 3-cycle stall between beats 1 and 2.
    run_sample("stall", 1, 3);

    // Tie between neurons 2 and 13.
    fill(10'sh000); sv[2] = 10'sh100; sv[13] = 10'sh100; sy[2] = 1'b1;
    run_sample("tie", -1, 0);

    // All negative, two label bits set.
    fill(10'sh3FF); sv[5] = 10'sh3FE; sy[0] = 1'b1; sy[7] = 1'b1;
    run_sample("allneg", -1, 0);

    // Abort on beat 2 after a partial sample carrying a large value.
    fill(10'sh000); sv[3] = 10'sh1FF;
    drive_beat(0); @(posedge clk); #1;
    drive_beat(1); @(posedge clk); #1;
    drive_beat(2); abort = 1'b1; @(posedge clk); #1;
    abort = 1'b0; act_valid = 1'b0;
    chk("abort.rv", {30'd0, rv[1], rv[0]}, 32'd0);
    fill(10'sh020); sv[11] = 10'sh050; sy[11] = 1'b1;
    run_sample("post_abort", -1, 0);

    // Asynchronous reset in the middle of a sample.
    drive_beat(0); @(posedge clk); #1;
    drive_beat(1); @(posedge clk); #2;
    reset = 1'b1; #1;
    chk_zero("midreset");
    act_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    wc[0] = 0; wc[1] = 0; cc[0] = 0; cc[1] = 0;

    // Window of four: correct 1,0,1,1 -> acc_count 3.
    win_sample(4, 1'b1);  run_sample("win0", -1, 0);
    win_sample(8, 1'b0);  run_sample("win1", -1, 0);
    win_sample(15, 1'b1); run_sample("win2", -1, 0);
    win_sample(0, 1'b1);  run_sample("win3", -1, 0);
    win_sample(6, 1'b0);  run_sample("win4", -1, 0);

    // Randomised samples with ties, stalls and assorted labels.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NN; i++)
        sv[i] = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 3) - 2);
      sy = '0;
      case ($urandom_range(0, 3))
        0: sy[$urandom_range(0, NN-1)] = 1'b1;
        1: begin
          mx = -(1 << (W-1)); first = 0;
          for (int i = 0; i < NN; i++) if (int'(sv[i]) > mx) begin mx = int'(sv[i]); first = i; end
          sy[first] = 1'b1;
        end
        2: sy = '0;
        default: begin sy[$urandom_range(0, 7)] = 1'b1; sy[$urandom_range(8, 15)] = 1'b1; end
      endcase
      run_sample($sformatf("rand%0d", t), $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 2)) : -1,
                 int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
